// File: rtl/wb_dbg_master_if.sv
// wb_dbg_master_if: 32-bit Wishbone master port bundle for the debug initiator
// Signals keep the initiator-side names; master drives the _o members, slave drives the _i members.
interface wb_dbg_master_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );
    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/wb_dbg_master.sv
// wb_dbg_master: byte-stream command protocol to single 32-bit Wishbone master cycles
// Ports: wb_clk_i/wb_rst_i clock and sync reset; rx_data/rx_valid command bytes in;
// tx_data/tx_valid/tx_ready response bytes out; wb Wishbone master port;
// busy_o high outside IDLE; overrun_o sticky flag for bytes dropped during BUS/RESP.
module wb_dbg_master #(
    parameter int TIMEOUT = 1024
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    wb_dbg_master_if.master        wb,
    output logic                   busy_o,
    output logic                   overrun_o
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;
    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        we_q;
    logic        cyc_q;
    logic        bus_we_q;
    logic        busy_q;
    logic        ovr_q;
    logic        txv_q;
    logic [7:0]  txd_q;
    logic [15:0] to_q;
    logic [31:0] adr_q;
    logic [31:0] dat_q;
    logic [31:0] resp_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = cyc_q;
    assign wb.wb_we_o  = bus_we_q;
    assign wb.wb_sel_o = {4{cyc_q}};
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign tx_data     = txd_q;
    assign tx_valid    = txv_q;
    assign busy_o      = busy_q;
    assign overrun_o   = ovr_q;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            cyc_q    <= 1'b0;
            bus_we_q <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            txv_q    <= 1'b0;
            txd_q    <= '0;
            to_q     <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            resp_q   <= '0;
        end else begin
            if (rx_valid && (state_q == BUS || state_q == RESP))
                ovr_q <= 1'b1;
            case (state_q)
                IDLE: if (rx_valid) begin
                    busy_q <= 1'b1;
                    cnt_q  <= '0;
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        we_q    <= rx_data == 8'h57;
                        state_q <= ADDR;
                    end else begin
                        txd_q   <= 8'h3F;
                        txv_q   <= 1'b1;
                        state_q <= RESP;
                    end
                end
                ADDR: if (rx_valid) begin
                    adr_q <= {adr_q[23:0], rx_data};
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q  <= we_q ? DATA : BUS;
                        cyc_q    <= !we_q;
                        bus_we_q <= 1'b0;
                        to_q     <= '0;
                    end
                end
                DATA: if (rx_valid) begin
                    dat_q <= {dat_q[23:0], rx_data};
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q  <= BUS;
                        cyc_q    <= 1'b1;
                        bus_we_q <= 1'b1;
                        to_q     <= '0;
                    end
                end
                BUS: begin
                    to_q <= to_q + 16'd1;
                    if (wb.wb_err_i || wb.wb_ack_i || to_q == 16'(TIMEOUT - 1)) begin
                        cyc_q    <= 1'b0;
                        bus_we_q <= 1'b0;
                        txv_q    <= 1'b1;
                        state_q  <= RESP;
                        cnt_q    <= '0;
                        // err has priority over ack; timeout only matters when neither arrived
                        if (!wb.wb_err_i && wb.wb_ack_i && !we_q) begin
                            txd_q  <= wb.wb_dat_i[31:24];
                            resp_q <= {wb.wb_dat_i[23:0], 8'h00};
                            cnt_q  <= 2'd3;
                        end else begin
                            txd_q <= (!wb.wb_err_i && wb.wb_ack_i) ? 8'h4B : 8'h45;
                        end
                    end
                end
                RESP: if (tx_ready) begin
                    if (cnt_q == 2'd0) begin
                        txv_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        txd_q  <= resp_q[31:24];
                        resp_q <= {resp_q[23:0], 8'h00};
                        cnt_q  <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_dbg_master.sv
// tb_wb_dbg_master: vector table, corner sequences and random traffic against a reference model
module tb_wb_dbg_master;
    localparam int TO = 8;
    localparam logic [7:0] CW = 8'h57;
    localparam logic [7:0] CR = 8'h52;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic tx_valid;
    logic tx_ready = 1'b1;
    logic busy;
    logic ovr;
    wb_dbg_master_if wb();
    wb_dbg_master #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb(wb), .busy_o(busy), .overrun_o(ovr)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int errors = 0;
    // slave: mode 0 ack, 1 err, 2 err+ack, 3 silent; terminates in stb cycle number wt (0-based)
    int mode = 0;
    int wt = 0;
    logic use_mem = 1'b0;
    logic mem_clr = 1'b1;
    logic [31:0] rdat = '0;
    int scnt = 0;
    logic [31:0] mem [16];
    logic hit;
    always @(posedge clk) scnt <= wb.wb_stb_o ? scnt + 1 : 0;
    assign hit = wb.wb_stb_o && scnt == wt;
    assign wb.wb_ack_i = hit && (mode == 0 || mode == 2);
    assign wb.wb_err_i = hit && (mode == 1 || mode == 2);
    assign wb.wb_dat_i = use_mem ? mem[wb.wb_adr_o[5:2]] : rdat;
    always @(posedge clk)
        if (mem_clr) for (int i = 0; i < 16; i++) mem[i] <= '0;
        else if (wb.wb_ack_i && wb.wb_we_o) mem[wb.wb_adr_o[5:2]] <= wb.wb_dat_o;
    int stb_cnt = 0;
    int unstable = 0;
    logic prev_stb = 1'b0;
    logic [31:0] m_adr = '0;
    logic [31:0] m_dat = '0;
    logic m_we = 1'b0;
    logic [3:0] m_sel = '0;
    always @(posedge clk) begin
        prev_stb <= wb.wb_stb_o && !rst;
        if (wb.wb_stb_o) begin
            stb_cnt <= stb_cnt + 1;
            m_adr <= wb.wb_adr_o;
            m_dat <= wb.wb_dat_o;
            m_we  <= wb.wb_we_o;
            m_sel <= wb.wb_sel_o;
            if (!wb.wb_cyc_o || (prev_stb && (wb.wb_adr_o !== m_adr || wb.wb_dat_o !== m_dat || wb.wb_we_o !== m_we)))
                unstable <= unstable + 1;
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
    endtask
    task automatic resp(input string nm, input logic [31:0] w, input int n, input int st_at, input int st_len);
        int got = 0;
        int stalled = 0;
        int cyc = 0;
        logic first = 1'b1;
        logic [7:0] e;
        while (got < n && cyc < 200) begin
            e = (n == 1) ? w[7:0] : w[31 - 8 * got -: 8];
            tx_ready = !(got == st_at && stalled < st_len);
            if (tx_valid) begin
                if (first) begin
                    first = 1'b0;
                    chk({nm, " bus off"}, {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o}, 0);
                end
                if (!tx_ready) begin
                    stalled++;
                    chk({nm, " hold"}, tx_data, e);
                end else begin
                    chk($sformatf("%s byte%0d", nm, got), tx_data, e);
                    got++;
                end
            end
            tick;
            cyc++;
        end
        tx_ready = 1'b1;
        if (got < n) chk({nm, " resp timeout"}, got, n);
        chk({nm, " idle"}, {tx_valid, busy}, 0);
    endtask
    task automatic cmd(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp, input int nb, input int slen, input int st_at, input int st_len);
        int s0;
        s0 = stb_cnt;
        send(op);
        if (op == CW || op == CR) begin
            for (int i = 0; i < 4; i++) send(a[31 - 8 * i -: 8]);
            if (op == CW) for (int i = 0; i < 4; i++) send(d[31 - 8 * i -: 8]);
            chk({nm, " cyc rise"}, {wb.wb_cyc_o, wb.wb_stb_o}, 2'b11);
        end
        resp(nm, exp, nb, st_at, st_len);
        chk({nm, " stb len"}, stb_cnt - s0, slen);
        chk({nm, " stable"}, unstable, 0);
        if (slen > 0) begin
            chk({nm, " adr"}, m_adr, a);
            chk({nm, " we/sel"}, {m_we, m_sel}, {op == CW, 4'hF});
            if (op == CW) chk({nm, " dat"}, m_dat, d);
        end
    endtask
    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        int          md;
        int          w;
        logic [31:0] rd;
        logic [31:0] exp;
        int          nb;
        int          sl;
    } vec_t;
    vec_t v [8];
    logic [31:0] model [16];
    initial begin
        v[0] = '{CW, 32'h00000010, 32'hDEADBEEF, 0, 2, 32'h0, 32'h4B, 1, 3};
        v[1] = '{CR, 32'h20000004, 32'h0, 0, 0, 32'h12345678, 32'h12345678, 4, 1};
        v[2] = '{CR, 32'h00000100, 32'h0, 2, 1, 32'hFFFFFFFF, 32'h45, 1, 2};
        v[3] = '{CR, 32'hF0000000, 32'h0, 3, 0, 32'h0, 32'h45, 1, TO};
        v[4] = '{CR, 32'h00000030, 32'h0, 0, 1, 32'h0BADC0DE, 32'h0BADC0DE, 4, 2};
        v[5] = '{CW, 32'h00000008, 32'h01020304, 1, 0, 32'h0, 32'h45, 1, 1};
        v[6] = '{CR, 32'h00000044, 32'h0, 0, TO - 1, 32'hCAFEF00D, 32'hCAFEF00D, 4, TO};
        v[7] = '{8'h41, 32'h0, 32'h0, 0, 0, 32'h0, 32'h3F, 1, 0};
        repeat (3) tick;
        rst = 1'b0;
        mem_clr = 1'b0;
        chk("rst ctl", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o, wb.wb_sel_o}, 0);
        chk("rst adr", wb.wb_adr_o, 0);
        chk("rst dat", wb.wb_dat_o, 0);
        chk("rst tx", {tx_valid, tx_data}, 0);
        chk("rst flags", {busy, ovr}, 0);
        for (int i = 0; i < 8; i++) begin
            mode = v[i].md;
            wt = v[i].w;
            rdat = v[i].rd;
            cmd($sformatf("vec%0d", i), v[i].op, v[i].a, v[i].d, v[i].exp, v[i].nb, v[i].sl, -1, 0);
        end
        chk("no overrun", ovr, 0);
        mode = 0; wt = 0; rdat = 32'h12345678;
        cmd("backpressure", CR, 32'h20000004, 0, 32'h12345678, 4, 1, 1, 5);
        mode = 2; wt = 3; rdat = 32'h11111111;
        send(CR);
        for (int i = 0; i < 4; i++) send(8'h00);
        send(8'h41);
        chk("overrun set", ovr, 1);
        resp("err+ack", 32'h45, 1, -1, 0);
        cmd("unknown", 8'h41, 0, 0, 32'h3F, 1, 0, -1, 0);
        chk("overrun sticky", ovr, 1);
        mode = 3;
        send(CR);
        for (int i = 0; i < 4; i++) send(8'h10);
        tick;
        chk("stb before rst", wb.wb_stb_o, 1);
        rst = 1'b1;
        tick;
        chk("mid rst", {wb.wb_cyc_o, wb.wb_stb_o, tx_valid, busy, ovr}, 0);
        rst = 1'b0;
        tick;
        mode = 0; wt = 0;
        cmd("post rst", CW, 32'h0, 32'h55AA55AA, 32'h4B, 1, 1, -1, 0);
        mem_clr = 1'b1;
        tick;
        mem_clr = 1'b0;
        use_mem = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        for (int n = 0; n < 40; n++) begin
            int idx, sl, nb;
            logic ok, isw;
            logic [31:0] a, d, exp;
            idx = $urandom_range(0, 15);
            a = ($urandom & 32'hFFFFFFC0) | (idx << 2);
            d = $urandom;
            wt = $urandom_range(0, TO + 1);
            mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
            isw = $urandom_range(0, 1) == 1;
            ok = wt < TO && mode == 0;
            sl = wt < TO ? wt + 1 : TO;
            if (isw) begin
                exp = ok ? 32'h4B : 32'h45;
                nb = 1;
                if (ok) model[idx] = d;
            end else begin
                exp = ok ? model[idx] : 32'h45;
                nb = ok ? 4 : 1;
            end
            cmd($sformatf("rnd%0d", n), isw ? CW : CR, a, d, exp, nb, sl, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
